pipe_reg_elastic: RTL and testbench
===================================

Name: pipe_reg_elastic

Overview:
- Parametrised, elastic replacement for the fixed IF/ID, ID/EX and EX/WB pipeline registers of the ri5cy core.
- Contains NUM_SLICES cascaded skid-buffer slices with a valid/ready handshake on each side, a synchronous flush and an occupancy count.
- Gives full throughput with no combinational path from out_ready_i to in_ready_o, so the pipeline_control unit can stall and flush any stage uniformly.

Parameters:
- DATA_WIDTH, 32 (WORD_WIDTH): payload width in bits.
- NUM_SLICES, 1: number of cascaded 2-entry slices. Legal range 1..8.
- CNT_W, $clog2(2*NUM_SLICES+1): occupancy counter width. Derived; not to be overridden.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- flush_i  in  1  discard all held entries at the next edge.
- in_valid_i  in  1  upstream payload valid.
- in_ready_o  out  1  block can accept a payload this cycle.
- in_data_i  in  DATA_WIDTH  upstream payload.
- out_valid_o  out  1  output payload valid.
- out_ready_i  in  1  downstream accepts the payload this cycle.
- out_data_o  out  DATA_WIDTH  output payload.
- occupancy_o  out  CNT_W  number of entries held, 0..2*NUM_SLICES.

Behaviour:
- Reset: all registers change only on the clk rising edge while rst_n=0. Reset overrides every other input.
  - Values in reset: out_valid_o=0, in_ready_o=1, out_data_o=0, occupancy_o=0, all slice data registers=0.
  - Reset asserted mid-operation discards all entries.
- Transfers: an input transfer occurs when in_valid_i & in_ready_o; an output transfer occurs when out_valid_o & out_ready_i.
- Slice structure: each slice holds a main register and a skid register, with state EMPTY, ONE or FULL.
  - slice in_ready = (state != FULL).
  - slice out_valid = (state != EMPTY).
  - slice out_data = main register.
- Slice state transitions (push = input transfer into the slice, pop = output transfer from the slice):
  - EMPTY, push: main <= in, go to ONE.
  - ONE, push & pop: main <= in, stay ONE.
  - ONE, push & !pop: skid <= in, go to FULL.
  - ONE, !push & pop: go to EMPTY.
  - FULL, pop: main <= skid, go to ONE. No push is possible while FULL.
  - Any state, no push and no pop: hold.
- Chaining: slices are chained valid/ready. Slice 0 faces the in_* ports; slice NUM_SLICES-1 drives the out_* ports.
- Timing:
  - Latency from an accepted input to out_valid_o with the pipe empty: NUM_SLICES cycles.
  - Sustained throughput: 1 transfer per cycle while out_ready_i=1.
  - Order is strictly preserved.
- in_ready_o is a function of slice 0 state registers only. It never depends on out_ready_i or in_valid_i in the same cycle.
- Flush (flush_i=1, rst_n=1): at the next edge every slice goes to EMPTY and occupancy_o becomes 0.
  - An input presented in the same cycle is dropped.
  - An output transfer in the same cycle still counts as consumed by downstream; the block does not re-present that payload.
  - Data registers keep their old values. out_data_o is don't-care while out_valid_o=0.
- Occupancy: occupancy_o is a register updated at each edge.
  - +1 on an input transfer, -1 on an output transfer, unchanged on both or neither.
  - Forced to 0 on flush or reset.
  - Never exceeds 2*NUM_SLICES and never underflows. Overflow or underflow is an assertion failure in the bench.
- Full boundary: at occupancy 2*NUM_SLICES, in_ready_o=0. After one output transfer, in_ready_o returns to 1 no earlier than NUM_SLICES cycles later, once the freed entry propagates back to slice 0.
- Empty boundary: at occupancy 0, out_valid_o=0. out_ready_i is ignored.

Decomposition:
- Shared package riscv_defines:
  - WORD_WIDTH.
  - typedef enum logic [1:0] slice_state_t {SL_EMPTY, SL_ONE, SL_FULL}.
- Sub-module pipe_skid_slice: one 2-entry slice with DATA_WIDTH, the state machine and flush input. pipe_reg_elastic instantiates it NUM_SLICES times in a generate loop and adds the occupancy counter.

Test Plan:
- Reset: rst_n=0 for 2 cycles with in_valid_i=1, in_data_i=0xAAAA5555 -> out_valid_o=0, in_ready_o=1, occupancy_o=0, out_data_o=0. Asserting rst_n with no clk edge changes nothing.
- Streaming (NUM_SLICES=2): push 0x1..0x10 back-to-back with out_ready_i=1 -> 0x1 valid 2 cycles after acceptance, then one word per cycle in order, in_ready_o constantly 1, occupancy_o steady at 2.
- Backpressure (NUM_SLICES=2): out_ready_i=0, push 0x100..0x105 -> exactly 0x100..0x103 accepted, in_ready_o=0, occupancy_o=4. Then out_ready_i=1 -> 0x100..0x103 drain in order, followed by 0x104 and 0x105.
- Flush when full with in_valid_i=1, in_data_i=0xDEAD -> next cycle occupancy_o=0, out_valid_o=0, in_ready_o=1. 0xDEAD and the old entries never appear on out_data_o with out_valid_o=1.
- Simultaneous push/pop (NUM_SLICES=1, occupancy 1): in 0x7, pop 0x6 in the same cycle -> occupancy_o stays 1, out_data_o=0x7 next cycle.
- Reset mid-operation at occupancy 3 -> after one edge with rst_n=0, all outputs equal their reset values. A subsequent push of 0x9 emerges after NUM_SLICES cycles.

Source files
------------

// File: rtl/pipe_reg_elastic_pkg.sv
// Shared core definitions used by the elastic pipeline register and its slices.
// Carries the word width, the slice state encoding and the occupancy counter sizing.
package riscv_defines;

   localparam int WORD_WIDTH = 32;

   typedef enum logic [1:0] {
      SL_EMPTY = 2'd0,
      SL_ONE   = 2'd1,
      SL_FULL  = 2'd2
   } slice_state_t;

   // Counter must represent 0..2*num_slices inclusive.
   function automatic int occ_width(input int num_slices);
      return $clog2(2 * num_slices + 1);
   endfunction

endpackage

// File: rtl/pipe_reg_elastic_skid.sv
// One 2-entry skid-buffer slice: a main register feeding the output and a skid
// register that absorbs one extra word, so in_ready_o depends only on local state.
module pipe_skid_slice
   import riscv_defines::*;
#(
   parameter int DATA_WIDTH = WORD_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush_i,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   input  logic [DATA_WIDTH-1:0] in_data_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [DATA_WIDTH-1:0] out_data_o
);

   slice_state_t          state_p0;
   slice_state_t          state_n;
   logic [DATA_WIDTH-1:0] main_p0;
   logic [DATA_WIDTH-1:0] skid_p0;
   logic                  push;
   logic                  pop;
   logic                  ld_main_in;
   logic                  ld_main_skid;
   logic                  ld_skid;

   assign in_ready_o  = (state_p0 != SL_FULL);
   assign out_valid_o = (state_p0 != SL_EMPTY);
   assign out_data_o  = main_p0;

   assign push = in_valid_i & in_ready_o;
   assign pop  = out_valid_o & out_ready_i;

   always_comb begin
      state_n      = state_p0;
      ld_main_in   = 1'b0;
      ld_main_skid = 1'b0;
      ld_skid      = 1'b0;
      unique case (state_p0)
         SL_EMPTY: begin
            if (push) begin
               ld_main_in = 1'b1;
               state_n    = SL_ONE;
            end
         end
         SL_ONE: begin
            if (push && pop) begin
               ld_main_in = 1'b1;
            end else if (push) begin
               ld_skid = 1'b1;
               state_n = SL_FULL;
            end else if (pop) begin
               state_n = SL_EMPTY;
            end
         end
         SL_FULL: begin
            if (pop) begin
               ld_main_skid = 1'b1;
               state_n      = SL_ONE;
            end
         end
         default: state_n = SL_EMPTY;
      endcase
      // Flush empties the slice but leaves the data registers untouched.
      if (flush_i) begin
         state_n      = SL_EMPTY;
         ld_main_in   = 1'b0;
         ld_main_skid = 1'b0;
         ld_skid      = 1'b0;
      end
   end

   // ---- slice register stage ----
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_p0 <= SL_EMPTY;
         main_p0  <= '0;
         skid_p0  <= '0;
      end else begin
         state_p0 <= state_n;
         if (ld_main_in) begin
            main_p0 <= in_data_i;
         end else if (ld_main_skid) begin
            main_p0 <= skid_p0;
         end
         if (ld_skid) begin
            skid_p0 <= in_data_i;
         end
      end
   end

endmodule

// File: rtl/pipe_reg_elastic.sv
// Elastic pipeline register: NUM_SLICES cascaded skid slices with flush and an
// occupancy count. Input readiness comes from slice 0 registers only.
module pipe_reg_elastic
   import riscv_defines::*;
#(
   parameter int DATA_WIDTH = WORD_WIDTH,
   parameter int NUM_SLICES = 1,
   parameter int CNT_W      = occ_width(NUM_SLICES)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush_i,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   input  logic [DATA_WIDTH-1:0] in_data_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [DATA_WIDTH-1:0] out_data_o,
   output logic [CNT_W-1:0]      occupancy_o
);

   // Chain index i is the boundary in front of slice i; index NUM_SLICES is the output.
   logic                  vld_p [NUM_SLICES+1];
   logic                  rdy_p [NUM_SLICES+1];
   logic [DATA_WIDTH-1:0] dat_p [NUM_SLICES+1];
   logic                  in_xfer;
   logic                  out_xfer;
   logic [CNT_W-1:0]      occ_p0;

   assign vld_p[0]          = in_valid_i;
   assign dat_p[0]          = in_data_i;
   assign in_ready_o        = rdy_p[0];
   assign rdy_p[NUM_SLICES] = out_ready_i;
   assign out_valid_o       = vld_p[NUM_SLICES];
   assign out_data_o        = dat_p[NUM_SLICES];

   for (genvar i = 0; i < NUM_SLICES; i++) begin : g_slice
      pipe_skid_slice #(
         .DATA_WIDTH (DATA_WIDTH)
      ) u_slice (
         .clk         (clk),
         .rst_n       (rst_n),
         .flush_i     (flush_i),
         .in_valid_i  (vld_p[i]),
         .in_ready_o  (rdy_p[i]),
         .in_data_i   (dat_p[i]),
         .out_valid_o (vld_p[i+1]),
         .out_ready_i (rdy_p[i+1]),
         .out_data_o  (dat_p[i+1])
      );
   end

   assign in_xfer  = in_valid_i & in_ready_o;
   assign out_xfer = out_valid_o & out_ready_i;

   // ---- occupancy register stage ----
   always_ff @(posedge clk) begin
      if (!rst_n || flush_i) begin
         occ_p0 <= '0;
      end else if (in_xfer && !out_xfer) begin
         occ_p0 <= occ_p0 + CNT_W'(1);
      end else if (!in_xfer && out_xfer) begin
         occ_p0 <= occ_p0 - CNT_W'(1);
      end
   end

   assign occupancy_o = occ_p0;

endmodule

// File: tb/tb_pipe_reg_elastic.sv
// Bench for pipe_reg_elastic: a 2-slice and a 1-slice instance, directed scenarios
// followed by random traffic, all checked against a queue-based reference model.
module tb_pipe_reg_elastic;

   typedef struct {
      logic [31:0] d;
      int          t;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        iv  [2];
   logic        ir  [2];
   logic        ov  [2];
   logic        orr [2];
   logic        fl  [2];
   logic [31:0] id  [2];
   logic [31:0] od  [2];
   logic [2:0]  occ0;
   logic [1:0]  occ1;
   int          occ [2];
   int          vectors = 0;
   int          miscompares = 0;
   int          cyc = 0;
   bit          model_on = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always_comb begin
      occ[0] = int'(occ0);
      occ[1] = int'(occ1);
   end

   pipe_reg_elastic #(.DATA_WIDTH(32), .NUM_SLICES(2)) dut (
      .clk (clk), .rst_n (rst_n), .flush_i (fl[0]),
      .in_valid_i (iv[0]), .in_ready_o (ir[0]), .in_data_i (id[0]),
      .out_valid_o (ov[0]), .out_ready_i (orr[0]), .out_data_o (od[0]),
      .occupancy_o (occ0)
   );

   pipe_reg_elastic #(.DATA_WIDTH(32), .NUM_SLICES(1)) dut_ns1 (
      .clk (clk), .rst_n (rst_n), .flush_i (fl[1]),
      .in_valid_i (iv[1]), .in_ready_o (ir[1]), .in_data_i (id[1]),
      .out_valid_o (ov[1]), .out_ready_i (orr[1]), .out_data_o (od[1]),
      .occupancy_o (occ1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: FIFO of accepted words with acceptance cycle stamps.
   for (genvar g = 0; g < 2; g++) begin : mdl
      localparam int NS = (g == 0) ? 2 : 1;
      ent_t q[$];
      logic ix = 1'b0;
      logic ox = 1'b0;
      int   stamp = 0;

      always @(negedge clk) begin
         ix = 1'b0;
         ox = 1'b0;
         if (model_on) begin
            chk("occ", occ[g], q.size());
            chk("cap", 32'(q.size() <= 2 * NS), 32'd1);
            if (q.size() == 0) chk("empty_vld", 32'(ov[g]), 32'd0);
            if (q.size() == 2 * NS) chk("full_rdy", 32'(ir[g]), 32'd0);
            ix    = iv[g] & ir[g];
            ox    = ov[g] & orr[g];
            stamp = cyc;
            if (ox) begin
               chk("pop_nonempty", 32'(q.size() > 0), 32'd1);
               if (q.size() > 0) begin
                  chk("order", od[g], q[0].d);
                  chk("latency", 32'((cyc - q[0].t) >= NS), 32'd1);
               end
            end
         end
      end

      always @(posedge clk) begin
         if (model_on) begin
            if (!rst_n || fl[g]) begin
               q.delete();
            end else begin
               if (ox && q.size() > 0) void'(q.pop_front());
               if (ix) q.push_back('{d: id[g], t: stamp});
            end
         end
      end
   end

   initial begin
      int          n;
      int          ng;
      logic        acc;
      logic [31:0] got [8];

      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         iv[i] = 1'b1; orr[i] = 1'b0; fl[i] = 1'b0; id[i] = 32'hAAAA5555;
      end

      // Reset with traffic offered
      tick();
      model_on = 1'b1;
      tick();
      for (int i = 0; i < 2; i++) begin
         chk("rst_vld", 32'(ov[i]), 32'd0);
         chk("rst_rdy", 32'(ir[i]), 32'd1);
         chk("rst_occ", occ[i], 32'd0);
         chk("rst_dat", od[i], 32'd0);
         iv[i] = 1'b0;
      end
      rst_n = 1'b1;
      #2;
      chk("rst_hold_vld", 32'(ov[0]), 32'd0);
      chk("rst_hold_occ", occ[0], 32'd0);

      // Streaming on the 2-slice instance
      orr[0] = 1'b1;
      for (int j = 1; j <= 18; j++) begin
         iv[0] = (j <= 16);
         id[0] = 32'(j);
         if (j <= 16) chk("str_rdy", 32'(ir[0]), 32'd1);
         tick();
         chk("str_occ", occ[0], 32'((j < 2) ? j : ((j <= 16) ? 2 : 18 - j)));
         chk("str_vld", 32'(ov[0]), 32'(j >= 2 && j <= 17));
         if (j >= 2 && j <= 17) chk("str_dat", od[0], 32'(j - 1));
      end

      // Backpressure
      orr[0] = 1'b0;
      n = 0;
      for (int c = 0; c < 8; c++) begin
         iv[0] = 1'b1;
         id[0] = 32'h100 + 32'(n);
         acc   = ir[0];
         tick();
         n += int'(acc);
      end
      chk("bp_acc", 32'(n), 32'd4);
      chk("bp_rdy", 32'(ir[0]), 32'd0);
      chk("bp_occ", occ[0], 32'd4);
      orr[0] = 1'b1;
      ng = 0;
      for (int c = 0; c < 20; c++) begin
         iv[0] = (n < 6);
         id[0] = 32'h100 + 32'(n);
         acc   = iv[0] & ir[0];
         if (ov[0] && ng < 8) begin
            got[ng] = od[0];
            ng++;
         end
         tick();
         n += int'(acc);
         if (c == 0) chk("bp_rdy_lag", 32'(ir[0]), 32'd0);
         if (c == 1) chk("bp_rdy_back", 32'(ir[0]), 32'd1);
      end
      iv[0] = 1'b0;
      chk("bp_cnt", 32'(ng), 32'd6);
      for (int k = 0; k < 6; k++) chk("bp_seq", got[k], 32'h100 + 32'(k));

      // Flush when full
      orr[0] = 1'b0;
      for (int c = 0; c < 10 && occ[0] != 4; c++) begin
         iv[0] = 1'b1;
         id[0] = $urandom;
         tick();
      end
      chk("fl_pre_occ", occ[0], 32'd4);
      fl[0] = 1'b1; iv[0] = 1'b1; id[0] = 32'hDEAD;
      tick();
      fl[0] = 1'b0; iv[0] = 1'b0;
      chk("fl_occ", occ[0], 32'd0);
      chk("fl_vld", 32'(ov[0]), 32'd0);
      chk("fl_rdy", 32'(ir[0]), 32'd1);
      orr[0] = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         chk("fl_quiet", 32'(ov[0]), 32'd0);
      end

      // Simultaneous push/pop on the 1-slice instance
      orr[1] = 1'b0; iv[1] = 1'b1; id[1] = 32'h6;
      tick();
      chk("pp_occ0", occ[1], 32'd1);
      chk("pp_dat0", od[1], 32'h6);
      id[1] = 32'h7; orr[1] = 1'b1;
      chk("pp_rdy", 32'(ir[1]), 32'd1);
      tick();
      iv[1] = 1'b0; orr[1] = 1'b0;
      chk("pp_occ", occ[1], 32'd1);
      chk("pp_vld", 32'(ov[1]), 32'd1);
      chk("pp_dat", od[1], 32'h7);

      // Reset mid-operation at occupancy 3
      orr[0] = 1'b0;
      for (int k = 0; k < 3; k++) begin
         iv[0] = 1'b1;
         id[0] = 32'h50 + 32'(k);
         tick();
      end
      iv[0] = 1'b0;
      chk("mr_pre_occ", occ[0], 32'd3);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("mr_vld", 32'(ov[0]), 32'd0);
      chk("mr_rdy", 32'(ir[0]), 32'd1);
      chk("mr_occ", occ[0], 32'd0);
      chk("mr_dat", od[0], 32'd0);
      chk("mr_occ_ns1", occ[1], 32'd0);
      iv[0] = 1'b1; id[0] = 32'h9;
      tick();
      iv[0] = 1'b0;
      chk("mr_lat1", 32'(ov[0]), 32'd0);
      tick();
      chk("mr_lat2", 32'(ov[0]), 32'd1);
      chk("mr_dat9", od[0], 32'h9);

      // Random traffic with phases of varying downstream backpressure
      for (int c = 0; c < 3000; c++) begin
         int ph;
         ph = (c / 200) % 3;
         for (int i = 0; i < 2; i++) begin
            iv[i]  = ($urandom_range(0, 3) != 0);
            orr[i] = (ph == 0) ? ($urandom_range(0, 3) == 0) :
                     (ph == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
            fl[i]  = ($urandom_range(0, 40) == 0);
            id[i]  = $urandom;
         end
         tick();
      end
      for (int i = 0; i < 2; i++) begin
         iv[i] = 1'b0; orr[i] = 1'b0; fl[i] = 1'b0;
      end
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
